// File: rtl/imem_byte_loader_pkg.sv
// Shared constants and types for the IMEM byte loader.
//   state_e  : loader FSM states
//   START_B  : start-of-image byte
//   END_W    : end-of-image word
//   LANE_W   : byte-lane counter width
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  localparam logic [BYTE_W-1:0] START_B = 8'hFE;
  localparam logic [WORD_W-1:0] END_W   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/imem_byte_loader_byte_packer.sv
// Assembles four accepted bytes into one big-endian 32-bit word.
//   clk_i, reset_n : clock, async active-low reset
//   clear_i        : resynchronise lane counter and drop any partial word
//   accept_i       : byte_i is taken into the current lane
//   byte_i         : stream byte
//   word_valid_c   : lane-3 byte accepted this cycle (combinational)
//   word_c         : completed word, valid with word_valid_c (combinational)
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [LANE_W-1:0]  lane_q, lane_d;
  // Only lanes 0..2 need storage; lane 3 comes straight from byte_i.
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // Lane and shift register next state.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (accept_i) begin
      lane_d  = lane_q + LANE_W'(1);
      shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_c = accept_i && (lane_q == LANE_W'(3));
  assign word_c       = {shift_q, byte_i};

endmodule

// File: rtl/imem_byte_loader.sv
// Byte-serial program loader: packs host bytes into words, writes them to
// consecutive IMEM addresses and releases the CPU once the image ends.
//   clk_i, reset_n : clock, async active-low reset
//   byte_valid_i   : byte_i valid this cycle
//   byte_i         : stream byte
//   imem_we_o      : one-cycle IMEM write strobe
//   imem_addr_o    : IMEM word address (holds between strobes)
//   imem_data_o    : IMEM write data (holds between strobes)
//   cpu_run_o      : CPU may run
//   load_done_o    : image complete
//   overflow_o     : sticky, more than DEPTH words received
//   word_count_o   : words written so far
module imem_byte_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_data_o,
  output logic              cpu_run_o,
  output logic              load_done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                start_hit;
  logic                accept;
  logic                word_valid_c;
  logic [WORD_W-1:0]   word_c;

  assign start_hit = byte_valid_i && (byte_i == START_B);
  assign accept    = byte_valid_i && (state_q == ST_LOAD);

  byte_packer u_packer (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .clear_i      (start_hit && (state_q != ST_LOAD)),
    .accept_i     (accept),
    .byte_i       (byte_i),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // FSM next state, write stage and status.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_hit) begin
          state_d = ST_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (word_valid_c) begin
          if (word_c == END_W) begin
            state_d = ST_DONE;
          end else if (count_q < CNT_W'(DEPTH)) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            data_d  = word_c;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Run lags done by one cycle so IMEM is settled before the CPU starts.
    done_d = (state_d == ST_DONE);
    run_d  = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      run_q   <= run_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign cpu_run_o    = run_q;
  assign load_done_o  = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Directed self-checking bench for imem_byte_loader.
module tb_imem_byte_loader;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        cpu_run_o;
  logic        load_done_o;
  logic        overflow_o;
  logic [6:0]  word_count_o;

  int n_cmp = 0;
  int n_err = 0;

  int          wr_n = 0;
  int          wr_addr [0:255];
  logic [31:0] wr_data [0:255];

  imem_byte_loader dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .cpu_run_o    (cpu_run_o),
    .load_done_o  (load_done_o),
    .overflow_o   (overflow_o),
    .word_count_o (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Write log, sampled just after each rising edge.
  always @(posedge clk_i) begin
    #1;
    if (imem_we_o === 1'b1 && wr_n < 256) begin
      wr_addr[wr_n] = int'(imem_addr_o);
      wr_data[wr_n] = imem_data_o;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i       = b;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--)
      send(w[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr, input logic [31:0] data);
    chk({tag, "_addr"}, 32'(wr_addr[idx]), 32'(addr));
    chk({tag, "_data"}, wr_data[idx], data);
  endtask

  logic [31:0] prog [0:2];
  int base;

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_8133;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_we",    32'(imem_we_o),    32'd0);
    chk("rst_addr",  32'(imem_addr_o),  32'd0);
    chk("rst_data",  imem_data_o,       32'd0);
    chk("rst_run",   32'(cpu_run_o),    32'd0);
    chk("rst_done",  32'(load_done_o),  32'd0);
    chk("rst_ovf",   32'(overflow_o),   32'd0);
    chk("rst_cnt",   32'(word_count_o), 32'd0);
    reset_n = 1'b1;

    // 1: basic image with latency checks
    idle(2);
    base = wr_n;
    send(8'h12, 0);            // ignored in IDLE
    send(8'hFE, 0);
    send_word(prog[0], 0);
    idle(1);
    chk("t1_we_lat",   32'(imem_we_o),   32'd1);
    chk("t1_addr_lat", 32'(imem_addr_o), 32'd0);
    chk("t1_data_lat", imem_data_o,      32'h0000_0013);
    idle(1);
    chk("t1_we_pulse", 32'(imem_we_o),   32'd0);
    chk("t1_hold",     imem_data_o,      32'h0000_0013);
    send_word(prog[1], 0);
    send_word(prog[2], 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(1);
    chk("t1_done",     32'(load_done_o), 32'd1);
    chk("t1_run_early",32'(cpu_run_o),   32'd0);
    idle(1);
    chk("t1_run",      32'(cpu_run_o),   32'd1);
    chk("t1_cnt",      32'(word_count_o),32'd3);
    chk("t1_nwr",      32'(wr_n - base), 32'd3);
    for (int k = 0; k < 3; k++) chk_wr("t1_wr", base + k, k, prog[k]);

    // 2: same stream with random gaps
    base = wr_n;
    send(8'hFE, 2);
    for (int k = 0; k < 3; k++) send_word(prog[k], 5);
    send_word(32'hFFFF_FFFF, 5);
    idle(6);
    chk("t2_nwr",  32'(wr_n - base), 32'd3);
    for (int k = 0; k < 3; k++) chk_wr("t2_wr", base + k, k, prog[k]);
    chk("t2_done", 32'(load_done_o),  32'd1);
    chk("t2_run",  32'(cpu_run_o),    32'd1);
    chk("t2_cnt",  32'(word_count_o), 32'd3);

    // 3: FF runs off the word boundary are data
    base = wr_n;
    send(8'hFE, 0);
    send_word(32'hFFFF_FF00, 0);
    send_word(32'h00FF_FFFF, 0);
    idle(2);
    chk("t3_not_done", 32'(load_done_o), 32'd0);
    chk("t3_nwr_mid",  32'(wr_n - base), 32'd2);
    send_word(32'hFFFF_FFFF, 0);
    idle(2);
    chk_wr("t3_wr0", base + 0, 0, 32'hFFFF_FF00);
    chk_wr("t3_wr1", base + 1, 1, 32'h00FF_FFFF);
    chk("t3_done", 32'(load_done_o),  32'd1);
    chk("t3_cnt",  32'(word_count_o), 32'd2);

    // 4: overflow with 65 words
    base = wr_n;
    send(8'hFE, 0);
    for (int k = 0; k < 65; k++) send_word(32'hA000_0000 + 32'(k), 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(2);
    chk("t4_nwr",  32'(wr_n - base),  32'd64);
    for (int k = 0; k < 64; k++) chk_wr("t4_wr", base + k, k, 32'hA000_0000 + 32'(k));
    chk("t4_ovf",  32'(overflow_o),   32'd1);
    chk("t4_cnt",  32'(word_count_o), 32'd64);
    chk("t4_done", 32'(load_done_o),  32'd1);
    chk("t4_run",  32'(cpu_run_o),    32'd1);

    // 6: restart from DONE clears status
    base = wr_n;
    send(8'hFE, 0);
    idle(1);
    chk("t6_run_drop",  32'(cpu_run_o),    32'd0);
    chk("t6_done_drop", 32'(load_done_o),  32'd0);
    chk("t6_ovf_clr",   32'(overflow_o),   32'd0);
    chk("t6_cnt_clr",   32'(word_count_o), 32'd0);
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(3);
    chk("t6_nwr", 32'(wr_n - base), 32'd1);
    chk_wr("t6_wr", base, 0, 32'h1234_5678);
    chk("t6_run", 32'(cpu_run_o),    32'd1);
    chk("t6_cnt", 32'(word_count_o), 32'd1);

    // 5: asynchronous reset mid-image
    send(8'hFE, 0);
    send_word(32'h1122_3344, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_we",   32'(imem_we_o),    32'd0);
    chk("t5_addr", 32'(imem_addr_o),  32'd0);
    chk("t5_data", imem_data_o,       32'd0);
    chk("t5_run",  32'(cpu_run_o),    32'd0);
    chk("t5_done", 32'(load_done_o),  32'd0);
    chk("t5_ovf",  32'(overflow_o),   32'd0);
    chk("t5_cnt",  32'(word_count_o), 32'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
    base = wr_n;
    send(8'hFE, 1);
    send_word(32'hCAFE_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(3);
    chk("t5_nwr", 32'(wr_n - base), 32'd1);
    chk_wr("t5_wr", base, 0, 32'hCAFE_0001);
    chk("t5_cnt", 32'(word_count_o), 32'd1);
    chk("t5_fin", 32'(cpu_run_o),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
